imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
Parametrised, clocked instruction memory with a program-load port and a valid/ready fetch interface for the RISC-V core.
- Byte addresses are converted to word indices.
- Reads are registered, with one cycle of latency.
- Misaligned and out-of-range fetches are flagged and return a NOP.
- A mode FSM separates program loading from instruction fetch.

Parameters:
Width, 32, instruction/data word width in bits
DepthWords, 512, number of instruction words stored
AddrWidth, 32, byte-address width of fetch and load ports
NopWord, 32'h00000013, word returned on a faulted fetch (addi x0,x0,0)
CountWidth, 16, width of fetch counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_mode  in  1  1 = request load mode, 0 = request run mode
ld_en  in  1  write strobe for load port
ld_addr  in  AddrWidth  byte address of word to write; bits[1:0] ignored
ld_data  in  Width  word to write
ld_par_inv  in  1  parity-inversion request for the word being written (used only with IMEM_PARITY_EN)
req_valid  in  1  fetch request valid
req_addr  in  AddrWidth  fetch byte address (PC)
req_ready  out  1  fetch request accepted this cycle when high with req_valid
rsp_valid  out  1  response register holds a word
rsp_data  out  Width  fetched instruction, or NopWord on fault
rsp_fault  out  2  bit0 = misaligned (addr[1:0]!=0), bit1 = out of range
rsp_ready  in  1  consumer accepts response
par_err  out  1  parity error on the current response
mode_o  out  2  FSM state: 0 IDLE, 1 LOAD, 2 RUN, 3 DRAIN
fetch_count  out  CountWidth  number of accepted fetches

Behaviour:
- Reset (async, rst_n=0): mode_o=IDLE, rsp_valid=0, rsp_data=0, rsp_fault=0, par_err=0, fetch_count=0. Memory array is not cleared.
- FSM, evaluated at each clk edge:
  - IDLE -> LOAD if load_mode=1, else IDLE -> RUN.
  - LOAD -> RUN when load_mode=0.
  - RUN -> DRAIN when load_mode=1.
  - DRAIN -> LOAD once rsp_valid=0, evaluated at the edge. If load_mode returns to 0 while in DRAIN, go to RUN instead.
- Word index = addr >> 2. Out of range when index >= DepthWords.
- Load port:
  - A write occurs on an edge with mode_o=LOAD, ld_en=1 and index in range.
  - Otherwise the write is silently dropped; this includes writes in every state other than LOAD.
  - The written word is readable from the next cycle.
- Fetch handshake:
  - req_ready = (mode_o==RUN) && (!rsp_valid || rsp_ready), combinational.
  - A request accepted at edge N gives rsp_valid=1 after edge N, carrying data, fault and par_err for that request.
  - While rsp_valid=1 and rsp_ready=0, all response outputs hold stable.
  - A response consumed at edge N with no accept at N gives rsp_valid=0 after N.
  - Accept and consume at the same edge: the register loads the new response and rsp_valid stays 1. This gives back-to-back throughput of 1 word/cycle.
- Fault:
  - rsp_fault = {out_of_range, misaligned}.
  - If either bit is set, rsp_data=NopWord and the memory value is not used.
  - Both bits can be set together.
- fetch_count increments on every accepted request, faulted or not, and wraps modulo 2^CountWidth.
- Reset mid-operation: the in-flight response is discarded immediately and the FSM returns to IDLE.

Optional Feature:
Macro: IMEM_PARITY_EN
- Defined:
  - Each stored word carries one even-parity bit, computed at write as ^ld_data ^ ld_par_inv.
  - On a non-faulted fetch, par_err=1 when the recomputed parity mismatches the stored bit; rsp_data still returns the stored word.
  - On a faulted fetch, par_err=0.
- Undefined:
  - No parity storage.
  - par_err is tied to 0.
  - ld_par_inv is ignored.

Test Plan:
- Reset, load_mode=1, then load words 0x002081B3 at address 0x0 and 0x403202B3 at address 0x4, then load_mode=0, then fetch 0x0 and 0x4 back-to-back with rsp_ready=1 -> the first response appears one cycle after accept, rsp_data=0x002081B3 then 0x403202B3, rsp_valid continuous, fetch_count=2.
- Fetch addr 0x2 -> rsp_fault=2'b01, rsp_data=0x00000013. Fetch addr 0x800 with DepthWords=512 -> rsp_fault=2'b10. Fetch addr 0x802 -> rsp_fault=2'b11.
- Backpressure: rsp_ready=0 for 3 cycles after a response -> req_ready=0 and rsp_data/rsp_fault stable; on rsp_ready=1 the next request is accepted in the same cycle.
- Set load_mode=1 while a response is pending with rsp_ready=0 -> mode_o=DRAIN; after rsp_ready=1 the response drains and mode_o=LOAD on the following edge. An ld_en pulse during DRAIN does not change memory.
- Deassert rst_n asynchronously mid-stream -> rsp_valid=0, mode_o=0, fetch_count=0 without waiting for a clock edge. Previously loaded words are still fetched correctly after re-entering RUN.
- IMEM_PARITY_EN defined: load addr 0x8 with ld_par_inv=1, then fetch 0x8 -> par_err=1 and data intact. Fetch 0x0, loaded with ld_par_inv=0 -> par_err=0.

Source files
------------

// File: rtl/imem_fetch_unit_if.sv
// Bus bundle for imem_fetch_unit: program-load port plus the valid/ready
// fetch request/response channel. The master side is the core (or the
// loader/bench); the slave side is the instruction memory.
interface imem_fetch_unit_if #(
    parameter int Width     = 32,
    parameter int AddrWidth = 32
);
    // Program-load port
    logic                 ld_en;
    logic [AddrWidth-1:0] ld_addr;
    logic [Width-1:0]     ld_data;
    logic                 ld_par_inv;

    // Fetch request channel
    logic                 req_valid;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_ready;

    // Fetch response channel
    logic                 rsp_valid;
    logic [Width-1:0]     rsp_data;
    logic [1:0]           rsp_fault;
    logic                 rsp_ready;
    logic                 par_err;

    modport master (
        output ld_en, ld_addr, ld_data, ld_par_inv,
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, par_err
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, ld_par_inv,
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_fault, par_err
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: clocked instruction memory for the RISC-V core.
// A mode FSM (IDLE/LOAD/RUN/DRAIN) separates program loading from fetch.
// Fetches are decoded combinationally (p0) and land in a single response
// register (p1), giving one cycle of latency and 1 word/cycle throughput.
// Misaligned or out-of-range fetches return NopWord with rsp_fault set.
// Optional feature: define IMEM_PARITY_EN to store one even-parity bit per
// word and report mismatches on par_err; otherwise par_err is tied low.
module imem_fetch_unit #(
    parameter int               Width      = 32,
    parameter int               DepthWords = 512,
    parameter int               AddrWidth  = 32,
    parameter logic [Width-1:0] NopWord    = 32'h00000013,
    parameter int               CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_mode,
    imem_fetch_unit_if.slave      bus,
    output logic [1:0]            mode_o,
    output logic [CountWidth-1:0] fetch_count
);

    localparam int IdxW  = AddrWidth - 2;
    localparam int MemAw = (DepthWords > 1) ? $clog2(DepthWords) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } mode_e;

    // Even parity over a full word.
    function automatic logic parity_of(input logic [Width-1:0] w);
        return ^w;
    endfunction

    // A word index addresses a stored word only below DepthWords.
    function automatic logic in_range(input logic [IdxW-1:0] idx);
        return idx < IdxW'(DepthWords);
    endfunction

    mode_e                 mode_q;
    mode_e                 mode_d;
    logic                  req_ready_w;
    logic                  ld_we;
    logic [IdxW-1:0]       ld_idx;

    logic [Width-1:0]      mem [DepthWords];

    logic [IdxW-1:0]       idx_p0;
    logic                  mis_p0;
    logic                  oor_p0;
    logic [1:0]            fault_p0;
    logic [Width-1:0]      word_p0;
    logic [Width-1:0]      data_p0;
    logic                  par_err_p0;
    logic                  accept_p0;

    logic                  vld_p1;
    logic [Width-1:0]      data_p1;
    logic [1:0]            fault_p1;
    logic                  par_err_p1;
    logic [CountWidth-1:0] count_q;

    // The two low load-address bits select a byte inside a word and are ignored.
    logic [1:0]            unused_ld_lsb;
    assign unused_ld_lsb = bus.ld_addr[1:0];

    assign ld_idx = bus.ld_addr[AddrWidth-1:2];

    // Mode register; reset returns the unit to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= IDLE;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode plus the per-mode enables: writes only in LOAD, fetch only in RUN.
    always_comb begin
        mode_d      = mode_q;
        req_ready_w = 1'b0;
        ld_we       = 1'b0;
        case (mode_q)
            IDLE: begin
                mode_d = load_mode ? LOAD : RUN;
            end
            LOAD: begin
                ld_we = bus.ld_en && in_range(ld_idx);
                if (!load_mode) begin
                    mode_d = RUN;
                end
            end
            RUN: begin
                req_ready_w = !vld_p1 || bus.rsp_ready;
                if (load_mode) begin
                    mode_d = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for the pending response to leave before loading;
                // a dropped load request goes straight back to fetching.
                if (!load_mode) begin
                    mode_d = RUN;
                end else if (!vld_p1) begin
                    mode_d = LOAD;
                end
            end
            default: begin
                mode_d = IDLE;
            end
        endcase
    end

    // Word storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx[MemAw-1:0]] <= bus.ld_data;
        end
    end

    // ---- p0: request decode and memory lookup ----
    assign idx_p0    = bus.req_addr[AddrWidth-1:2];
    assign mis_p0    = |bus.req_addr[1:0];
    assign oor_p0    = !in_range(idx_p0);
    assign fault_p0  = {oor_p0, mis_p0};
    assign word_p0   = mem[idx_p0[MemAw-1:0]];
    assign data_p0   = (|fault_p0) ? NopWord : word_p0;
    assign accept_p0 = bus.req_valid && req_ready_w;

`ifdef IMEM_PARITY_EN
    logic par_mem [DepthWords];

    // Parity side-array, written alongside the word; ld_par_inv lets a
    // loader plant a deliberately bad parity bit.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            par_mem[ld_idx[MemAw-1:0]] <= parity_of(bus.ld_data) ^ bus.ld_par_inv;
        end
    end

    assign par_err_p0 = (|fault_p0) ? 1'b0
                      : (parity_of(word_p0) != par_mem[idx_p0[MemAw-1:0]]);
`else
    logic unused_par_inv;
    assign unused_par_inv = bus.ld_par_inv;
    assign par_err_p0     = 1'b0;
`endif

    // ---- p1: response register ----
    // Loads on accept (also when the old response is consumed at the same
    // edge), clears on consume, and otherwise holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            fault_p1   <= 2'b00;
            par_err_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1     <= 1'b1;
            data_p1    <= data_p0;
            fault_p1   <= fault_p0;
            par_err_p1 <= par_err_p0;
        end else if (bus.rsp_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    // Accepted-request counter, faulted fetches included; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (accept_p0) begin
            count_q <= count_q + CountWidth'(1);
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_data  = data_p1;
    assign bus.rsp_fault = fault_p1;
    assign bus.par_err   = par_err_p1;
    assign mode_o        = mode_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed + randomized bench for imem_fetch_unit with a behavioural
// memory/response model kept in the bench.
module tb_imem_fetch_unit;

    localparam int          W   = 32;
    localparam int          D   = 512;
    localparam int          IW  = $clog2(D);
    localparam int          AW  = 32;
    localparam int          CW  = 6;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_mode = 1'b0;
    logic [1:0]    mode_o;
    logic [CW-1:0] fetch_count;

    imem_fetch_unit_if #(.Width(W), .AddrWidth(AW)) bus ();

    imem_fetch_unit #(
        .Width(W), .DepthWords(D), .AddrWidth(AW), .NopWord(NOP), .CountWidth(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_mode(load_mode),
        .bus(bus),
        .mode_o(mode_o),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        logic        perr;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int          m_count = 0;
    logic [31:0] ref_mem [D];
    bit          ref_inv [D];
    rsp_t        q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_count();
        logic [31:0] c;
        c = m_count % (1 << CW);
        return c;
    endfunction

    function automatic rsp_t expect_rsp(input logic [31:0] addr);
        rsp_t        r;
        logic [31:0] idx;
        idx     = addr >> 2;
        r.fault = {(idx >= D), (addr[1:0] != 2'b00)};
        if (r.fault != 2'b00) begin
            r.data = NOP;
            r.perr = 1'b0;
        end else begin
            r.data = ref_mem[idx[IW-1:0]];
            r.perr = PAR_EN && ref_inv[idx[IW-1:0]];
        end
        return r;
    endfunction

    // Only called while the DUT is in LOAD.
    task automatic load_word(input logic [31:0] addr, input logic [31:0] data, input bit inv);
        logic [31:0] idx;
        bus.ld_en      = 1'b1;
        bus.ld_addr    = addr;
        bus.ld_data    = data;
        bus.ld_par_inv = inv;
        tick();
        bus.ld_en      = 1'b0;
        idx = addr >> 2;
        if (idx < D) begin
            ref_mem[idx[IW-1:0]] = data;
            ref_inv[idx[IW-1:0]] = inv;
        end
    endtask

    // Single fetch in RUN with an empty response register.
    task automatic fetch_one(input logic [31:0] addr, input string tag,
                             input logic [1:0] ef, input logic [31:0] ed);
        rsp_t r;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        m_count++;
        r = expect_rsp(addr);
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        chk({tag, "_data"}, bus.rsp_data, ed);
        chk({tag, "_fault"}, bus.rsp_fault, ef);
        chk({tag, "_par_err"}, bus.par_err, r.perr);
        chk({tag, "_count"}, fetch_count, exp_count());
        tick();
        chk({tag, "_valid_drop"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] rnd;
        bit          exp_ready;
        bit          consume;
        bit          accept;

        bus.ld_en      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.ld_par_inv = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.rsp_ready  = 1'b0;
        load_mode      = 1'b1;

        // Reset values
        repeat (2) tick();
        chk("rst_mode", mode_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_fault", bus.rsp_fault, 0);
        chk("rst_par_err", bus.par_err, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_req_ready", bus.req_ready, 0);

        // IDLE -> LOAD
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mode_load", mode_o, 1);
        chk("load_req_ready", bus.req_ready, 0);

        // Program load
        load_word(32'h0, 32'h002081B3, 1'b0);
        load_word(32'h4, 32'h403202B3, 1'b0);
        load_word(32'h8, $urandom, 1'b1);
        for (int i = 3; i < 32; i++) begin
            a = i << 2;
            if (i == 5) a = a | 32'h3;
            load_word(a, $urandom, bit'($urandom_range(0, 1)));
        end
        load_word(32'h7FC, $urandom, 1'b0);
        // Out of range: must be dropped without aliasing onto word 0.
        bus.ld_en = 1'b1; bus.ld_addr = 32'h800; bus.ld_data = 32'hFFFFFFFF;
        tick();
        bus.ld_en = 1'b0;

        // LOAD -> RUN
        load_mode = 1'b0;
        tick();
        chk("mode_run", mode_o, 2);
        chk("run_req_ready", bus.req_ready, 1);
        chk("run_count0", fetch_count, 0);

        // Back-to-back fetch of 0x0 and 0x4
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("b2b_pre_valid", bus.rsp_valid, 0);
        tick();
        chk("b2b_valid0", bus.rsp_valid, 1);
        chk("b2b_data0", bus.rsp_data, 32'h002081B3);
        bus.req_addr = 32'h4;
        tick();
        chk("b2b_valid1", bus.rsp_valid, 1);
        chk("b2b_data1", bus.rsp_data, 32'h403202B3);
        chk("b2b_fault1", bus.rsp_fault, 0);
        bus.req_valid = 1'b0;
        tick();
        chk("b2b_valid_end", bus.rsp_valid, 0);
        chk("b2b_count", fetch_count, 2);
        m_count = 2;

        // Faults, last word, parity
        fetch_one(32'h2,   "mis",     2'b01, NOP);
        fetch_one(32'h800, "oor",     2'b10, NOP);
        fetch_one(32'h802, "both",    2'b11, NOP);
        fetch_one(32'h7FC, "last",    2'b00, ref_mem[D-1]);
        fetch_one(32'h8,   "par8",    2'b00, ref_mem[2]);
        fetch_one(32'h0,   "word0",   2'b00, 32'h002081B3);
        fetch_one(32'h14,  "word5",   2'b00, ref_mem[5]);
        chk("par8_expect", {31'd0, expect_rsp(32'h8).perr}, {31'd0, PAR_EN});

        // Backpressure
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h4;
        bus.rsp_ready = 1'b0;
        tick();
        m_count++;
        bus.req_addr = 32'h0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", bus.rsp_data, 32'h403202B3);
            chk("bp_fault", bus.rsp_fault, 0);
            chk("bp_count", fetch_count, exp_count());
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.req_ready, 1);
        tick();
        m_count++;
        chk("bp_next_valid", bus.rsp_valid, 1);
        chk("bp_next_data", bus.rsp_data, 32'h002081B3);
        chk("bp_next_count", fetch_count, exp_count());
        bus.req_valid = 1'b0;
        tick();
        chk("bp_drop", bus.rsp_valid, 0);

        // DRAIN -> LOAD, with a write attempt during DRAIN
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        bus.rsp_ready = 1'b0;
        tick();
        m_count++;
        bus.req_valid = 1'b0;
        load_mode = 1'b1;
        tick();
        chk("drain_mode", mode_o, 3);
        chk("drain_req_ready", bus.req_ready, 0);
        bus.ld_en = 1'b1; bus.ld_addr = 32'h0; bus.ld_data = 32'hDEADBEEF;
        tick();
        bus.ld_en = 1'b0;
        chk("drain_hold_mode", mode_o, 3);
        chk("drain_hold_data", bus.rsp_data, ref_mem[2]);
        bus.rsp_ready = 1'b1;
        tick();
        chk("drain_consumed", bus.rsp_valid, 0);
        chk("drain_still", mode_o, 3);
        tick();
        chk("drain_to_load", mode_o, 1);
        load_mode = 1'b0;
        tick();
        chk("reload_run", mode_o, 2);
        // Write attempt in RUN is dropped too.
        bus.ld_en = 1'b1; bus.ld_addr = 32'h4; bus.ld_data = 32'hCAFEF00D;
        tick();
        bus.ld_en = 1'b0;
        fetch_one(32'h0, "after_drain0", 2'b00, 32'h002081B3);
        fetch_one(32'h4, "after_run4",   2'b00, 32'h403202B3);

        // DRAIN -> RUN when load_mode drops again
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hC;
        bus.rsp_ready = 1'b0;
        tick();
        m_count++;
        bus.req_valid = 1'b0;
        load_mode = 1'b1;
        tick();
        chk("dr_mode", mode_o, 3);
        load_mode = 1'b0;
        tick();
        chk("dr_back_run", mode_o, 2);
        chk("dr_valid", bus.rsp_valid, 1);
        chk("dr_data", bus.rsp_data, ref_mem[3]);
        bus.rsp_ready = 1'b1;
        tick();
        chk("dr_drop", bus.rsp_valid, 0);

        // Randomized traffic against the response scoreboard
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom_range(0, 9);
            if (rnd < 7)       a = $urandom_range(0, 31) << 2;
            else if (rnd == 7) a = ($urandom_range(0, 31) << 2) | $urandom_range(1, 3);
            else               a = (($urandom_range(D, D + 200)) << 2) | $urandom_range(0, 3);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_addr  = a;
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (q.size() == 0) || bus.rsp_ready;
            chk("rand_req_ready", bus.req_ready, exp_ready);
            consume = (q.size() != 0) && bus.rsp_ready;
            accept  = bus.req_valid && exp_ready;
            tick();
            if (consume) void'(q.pop_front());
            if (accept) begin
                q.push_back(expect_rsp(a));
                m_count++;
            end
            chk("rand_valid", bus.rsp_valid, (q.size() != 0));
            if (q.size() != 0) begin
                chk("rand_data", bus.rsp_data, q[0].data);
                chk("rand_fault", bus.rsp_fault, q[0].fault);
                chk("rand_par_err", bus.par_err, q[0].perr);
            end
            chk("rand_count", fetch_count, exp_count());
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        q.delete();
        chk("rand_end_valid", bus.rsp_valid, 0);

        // Asynchronous reset with a response pending
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h4;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("ar_pending", bus.rsp_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.rsp_valid, 0);
        chk("ar_mode", mode_o, 0);
        chk("ar_count", fetch_count, 0);
        chk("ar_data", bus.rsp_data, 0);
        chk("ar_fault", bus.rsp_fault, 0);
        chk("ar_par_err", bus.par_err, 0);
        m_count = 0;
        load_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_run", mode_o, 2);
        fetch_one(32'h0, "ar_f0", 2'b00, 32'h002081B3);
        fetch_one(32'h4, "ar_f4", 2'b00, 32'h403202B3);
        fetch_one(32'h8, "ar_f8", 2'b00, ref_mem[2]);
        chk("ar_count3", fetch_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
